// File: rtl/hash_pkg.sv
// Shared definitions for the H3 hash request path: default widths and a
// helper that pulls one Q-matrix row out of the flat Q bus.
package hash_pkg;

  localparam int KEY_WIDTH_DEF   = 32;
  localparam int INDEX_WIDTH_DEF = 12;

  // Upper bounds the row extractor supports; callers zero-extend into this.
  localparam int MAX_KEY_WIDTH   = 64;
  localparam int MAX_INDEX_WIDTH = 32;
  localparam int MAX_Q_BITS      = MAX_KEY_WIDTH * MAX_INDEX_WIDTH;

  // Row `row` of a Q matrix whose rows are `index_width` bits wide, packed
  // row 0 at the LSBs. Bits above index_width are don't-care for the caller.
  function automatic logic [MAX_INDEX_WIDTH-1:0] q_row(
    input logic [MAX_Q_BITS-1:0] q,
    input int unsigned           row,
    input int unsigned           index_width
  );
    logic [MAX_Q_BITS-1:0] shifted;
    shifted = q >> (row * index_width);
    return shifted[MAX_INDEX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own rotating pointer. The grant is one-hot,
// gated by `advance`, and the pointer moves past the winner on each grant.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  // NOTE: every signal written here gets a default before any conditional
  // logic, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(N)) sum = sum - (ID_W + 1)'(N);
      idx = sum[ID_W-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    if (found && advance) grant[grant_id] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking '=' is reserved for combinational scratch logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found && advance) begin
      ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/hash_req_arbiter.sv
// Shares one XOR (H3) hash datapath among NUM_REQ requesters: round-robin
// accept into S1, hash into S2, S2 drives the registered valid/ready output.
module hash_req_arbiter
  import hash_pkg::*;
#(
  parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [INDEX_WIDTH*KEY_WIDTH-1:0] hash_q_in,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INDEX_WIDTH-1:0]         out_index,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic [KEY_WIDTH-1:0]           out_key
);

  logic                   s1_valid, s2_valid;
  logic                   s1_adv, s2_adv;
  logic [KEY_WIDTH-1:0]   s1_key, s2_key;
  logic [ID_WIDTH-1:0]    s1_id, s2_id;
  logic [INDEX_WIDTH-1:0] s2_index;

  logic [NUM_REQ-1:0]     grant;
  logic [ID_WIDTH-1:0]    grant_id;
  logic                   accept;
  logic [KEY_WIDTH-1:0]   grant_key;

  logic [MAX_Q_BITS-1:0]  q_ext;
  logic [INDEX_WIDTH-1:0] q_rows [KEY_WIDTH];
  logic [INDEX_WIDTH-1:0] hash_index;

  // S2 frees when empty or draining; S1 frees when empty or moving into S2.
  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_WIDTH)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (s1_adv),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // The arbiter only grants an asserted request, so any grant is a transfer.
  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    grant_key = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_id == ID_WIDTH'(r)) grant_key = req_key[KEY_WIDTH*r +: KEY_WIDTH];
    end
  end

  assign q_ext = MAX_Q_BITS'(hash_q_in);

  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_rows
    assign q_rows[i] = INDEX_WIDTH'(q_row(q_ext, i, INDEX_WIDTH));
  end

  always_comb begin
    hash_index = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (s1_key[i]) hash_index = hash_index ^ q_rows[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_key   <= '0;
      s1_id    <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_key <= grant_key;
        s1_id  <= grant_id;
      end
    end
  end

  // NOTE: the S2 payload is reset as well as its valid bit, because these
  // flops drive the outputs directly and must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_index <= '0;
      s2_key   <= '0;
      s2_id    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_index <= hash_index;
        s2_key   <= s1_key;
        s2_id    <= s1_id;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_index = s2_index;
  assign out_id    = s2_id;
  assign out_key   = s2_key;

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Self-checking bench for hash_req_arbiter: directed table vectors, round-robin,
// backpressure and reset sequences, then random traffic against a queue model.
module tb_hash_req_arbiter;

  localparam int KW  = 32;
  localparam int IW  = 12;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic              clk;
  logic              rst_n;
  logic [IW*KW-1:0]  hash_q_in;
  logic [NR-1:0]     req_valid;
  logic [NR*KW-1:0]  req_key;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_index;
  logic [IDW-1:0]    out_id;
  logic [KW-1:0]     out_key;

  hash_req_arbiter #(
    .KEY_WIDTH   (KW),
    .INDEX_WIDTH (IW),
    .NUM_REQ     (NR),
    .ID_WIDTH    (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hash_q_in (hash_q_in),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_id    (out_id),
    .out_key   (out_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [KW-1:0] key;
    logic [IW-1:0] index;
    int unsigned age;   // clock edges seen since the accepting edge
  } entry_t;

  typedef struct {
    int unsigned   rid;
    logic [KW-1:0] key;
    logic [IW-1:0] exp_index;
  } vec_t;

  entry_t      sb[$];
  int unsigned m_ptr;
  int          gap [NR];
  int          errors;
  int          checks;
  int          dut_accepts;
  int          dut_emits;

  function automatic logic [IW-1:0] row_val(input int i);
    if (i == 0) return 12'h423;
    if (i == 1) return 12'hB84;
    return IW'((i * 1103 + 337) ^ (i << 7));
  endfunction

  // Reference hash: XOR of the Q rows selected by the key's set bits.
  function automatic logic [IW-1:0] model_hash(input logic [KW-1:0] key);
    logic [IW-1:0] h;
    h = '0;
    for (int i = 0; i < KW; i++) begin
      if (((key >> i) & 1) != 0) h = h ^ IW'(hash_q_in >> (IW * i));
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0;
    for (int r = 0; r < NR; r++) gap[r] = 0;
  endtask

  // One clock cycle. Called just after a falling edge with inputs applied;
  // checks the DUT against the model, then advances the model across the edge.
  task automatic tick();
    logic [NR-1:0] exp_ready;
    logic          exp_ov;
    int            w;
    int unsigned   idx;
    entry_t        e;
    #2;
    exp_ready = '0;
    w = -1;
    if (req_valid != '0 && (sb.size() < 2 || out_ready)) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (w < 0 && ((req_valid >> idx) & 1) != 0) w = int'(idx);
      end
      exp_ready = NR'(1) << w;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    exp_ov = (sb.size() > 0) && (sb[0].age >= 1);
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check("out_index", 64'(out_index), 64'(sb[0].index));
      check("out_id",    64'(out_id),    64'(sb[0].id));
      check("out_key",   64'(out_key),   64'(sb[0].key));
    end
    if (w >= 0) begin
      check("starve_gap", 64'(gap[w] <= NR - 1), 64'(1));
      for (int r = 0; r < NR; r++) begin
        if (r == w) gap[r] = 0;
        else if (((req_valid >> r) & 1) != 0) gap[r]++;
        else gap[r] = 0;
      end
    end else begin
      for (int r = 0; r < NR; r++) if (((req_valid >> r) & 1) == 0) gap[r] = 0;
    end
    if ((req_valid & req_ready) != '0) dut_accepts++;
    if (out_valid && out_ready) dut_emits++;
    @(posedge clk);
    if (exp_ov && out_ready) void'(sb.pop_front());
    foreach (sb[i]) sb[i].age++;
    if (w >= 0) begin
      e.id    = w;
      e.key   = KW'(req_key >> (KW * w));
      e.index = model_hash(e.key);
      e.age   = 0;
      sb.push_back(e);
      m_ptr = (w + 1) % NR;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_outputs",   {20'(out_index), 12'(out_id), out_key}, 64'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [NR*KW-1:0] rand_keys();
    logic [NR*KW-1:0] k;
    for (int r = 0; r < NR; r++) k[KW*r +: KW] = $urandom;
    return k;
  endfunction

  vec_t         vecs [5];
  int           rr_count [NR];
  logic [63:0]  held;

  initial begin
    errors = 0; checks = 0; dut_accepts = 0; dut_emits = 0;
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; req_key = '0;
    for (int i = 0; i < KW; i++) hash_q_in[IW*i +: IW] = row_val(i);
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed single-key vectors: acceptance, 2-cycle latency, index, id.
    vecs[0] = '{rid: 0, key: 32'h0000_0001, exp_index: 12'h423};
    vecs[1] = '{rid: 2, key: 32'h0000_0003, exp_index: 12'hFA7};
    vecs[2] = '{rid: 2, key: 32'h0000_0000, exp_index: 12'h000};
    vecs[3] = '{rid: 1, key: 32'h0000_0002, exp_index: 12'hB84};
    vecs[4] = '{rid: 3, key: 32'h0000_0003, exp_index: 12'hFA7};
    for (int v = 0; v < 5; v++) begin
      req_key = rand_keys();
      req_key[KW*vecs[v].rid +: KW] = vecs[v].key;
      req_valid = NR'(1) << vecs[v].rid;
      out_ready = 1'b1;
      #1;
      check("vec_ready", 64'(req_ready), 64'(NR'(1) << vecs[v].rid));
      tick();
      req_valid = '0;
      check("vec_latency_n1", 64'(out_valid), 64'(0));
      tick();
      check("vec_valid_n2", 64'(out_valid), 64'(1));
      check("vec_index",    64'(out_index), 64'(vecs[v].exp_index));
      check("vec_id",       64'(out_id),    64'(vecs[v].rid));
      check("vec_key",      64'(out_key),   64'(vecs[v].key));
      tick();
    end

    // Round-robin: all requesters valid from pointer 0 for 8 accepts.
    @(negedge clk);
    do_reset();
    for (int r = 0; r < NR; r++) rr_count[r] = 0;
    req_valid = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_key = rand_keys();
      #1;
      check("rr_order", 64'(req_ready), 64'(NR'(1) << (c % NR)));
      for (int r = 0; r < NR; r++) if (((req_ready >> r) & 1) != 0) rr_count[r]++;
      tick();
    end
    for (int r = 0; r < NR; r++) check("rr_count", 64'(rr_count[r]), 64'(2));
    req_valid = '0;
    repeat (3) tick();

    // Backpressure: 5 stall cycles on a full pipeline, then drain.
    dut_accepts = 0;
    dut_emits   = 0;
    req_valid   = '1;
    out_ready   = 1'b1;
    repeat (3) begin
      req_key = rand_keys();
      tick();
    end
    out_ready = 1'b0;
    held = {20'(out_index), 12'(out_id), out_key};
    for (int s = 0; s < 5; s++) begin
      req_key = rand_keys();
      tick();
      check("stall_hold", {20'(out_index), 12'(out_id), out_key}, held);
      check("stall_valid", 64'(out_valid), 64'(1));
      if (s >= 1) check("stall_ready", 64'(req_ready), 64'(0));
    end
    out_ready = 1'b1;
    req_valid = '0;
    repeat (4) tick();
    check("no_loss", 64'(dut_emits), 64'(dut_accepts));
    check("drained", 64'(sb.size()), 64'(0));

    // Random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      for (int r = 0; r < NR; r++) req_valid[r] = ($urandom_range(3) != 0);
      req_key   = rand_keys();
      out_ready = ($urandom_range(9) < 7);
      tick();
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("rand_drained", 64'(sb.size()), 64'(0));

    // Reset while both stages hold keys.
    req_valid = '1;
    out_ready = 1'b1;
    repeat (2) begin
      req_key = rand_keys();
      tick();
    end
    out_ready = 1'b0;
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    req_key   = rand_keys();
    #1;
    check("first_grant_after_rst", 64'(req_ready), 64'(1));
    tick();
    check("no_stale_result", 64'(out_valid), 64'(0));
    repeat (4) begin
      req_key = rand_keys();
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
